rt_jtag_master: RTL and testbench



---
 rtl/rt_jtag_master_pkg.sv | 20 ++
 rtl/rt_jtag_master_if.sv | 35 +++
 rtl/rt_jtag_tck_gen.sv | 36 +++
 rtl/rt_jtag_master.sv | 121 ++++++++++++
 tb/tb_rt_jtag_master.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rt_jtag_master_pkg.sv
// rtl/rt_jtag_master_pkg.sv - shared types and constants for the JTAG shift engine
package rt_jtag_master_pkg;

    localparam int MaxLen   = 32;
    localparam int LenWidth = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        RESP
    } state_e;

    typedef struct packed {
        logic [LenWidth-1:0] len;
        logic [MaxLen-1:0]   tms;
        logic [MaxLen-1:0]   tdi;
    } jtag_cmd_t;

endpackage

// File: rtl/rt_jtag_master_if.sv
// rtl/rt_jtag_master_if.sv - command/response handshake and JTAG pin bundle
interface rt_jtag_master_if #(
    parameter int MAX_LEN = rt_jtag_master_pkg::MaxLen
);
    import rt_jtag_master_pkg::*;

    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [LenWidth-1:0] cmd_len_i;
    logic [MAX_LEN-1:0]  cmd_tms_i;
    logic [MAX_LEN-1:0]  cmd_tdi_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [MAX_LEN-1:0]  rsp_tdo_o;
    logic                jtag_tck_o;
    logic                jtag_tms_o;
    logic                jtag_td_o;
    logic                jtag_trst_no;
    logic                jtag_td_i;

    // Engine side
    modport slave (
        input  cmd_valid_i, cmd_len_i, cmd_tms_i, cmd_tdi_i, rsp_ready_i, jtag_td_i,
        output cmd_ready_o, rsp_valid_o, rsp_tdo_o,
        output jtag_tck_o, jtag_tms_o, jtag_td_o, jtag_trst_no
    );

    // Host / target side
    modport master (
        output cmd_valid_i, cmd_len_i, cmd_tms_i, cmd_tdi_i, rsp_ready_i, jtag_td_i,
        input  cmd_ready_o, rsp_valid_o, rsp_tdo_o,
        input  jtag_tck_o, jtag_tms_o, jtag_td_o, jtag_trst_no
    );

endinterface

// File: rtl/rt_jtag_tck_gen.sv
// rtl/rt_jtag_tck_gen.sv - TCK phase counter with rise/fall strobes for the upcoming edge
module rt_jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tck,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q;
    logic          tck_q;
    logic          wrap;

    // Strobes mark the system edge on which TCK is about to toggle.
    assign wrap = run && (cnt_q == CW'(CLK_DIV - 1));
    assign rise = wrap && !tck_q;
    assign fall = wrap && tck_q;
    assign tck  = tck_q;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (wrap) begin
            cnt_q <= '0;
            tck_q <= ~tck_q;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/rt_jtag_master.sv
// rtl/rt_jtag_master.sv - host-side JTAG shift engine, one command of up to 32 bits per transaction
module rt_jtag_master
    import rt_jtag_master_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = MaxLen
) (
    input  logic            clk_i,
    input  logic            rst_i,
    rt_jtag_master_if.slave bus
);

    state_e             state_q, state_d;
    jtag_cmd_t          cmd_q, cmd_d;
    logic [4:0]         idx_q, idx_d;
    logic [MAX_LEN-1:0] tdo_q, tdo_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               tms_q, tms_d;
    logic               td_q, td_d;
    logic               trst_n_q;

    logic run, tck, tck_rise, tck_fall;
    logic accept, len_legal, last_bit;

    assign run       = (state_q == LOW) || (state_q == HIGH);
    assign accept    = (state_q == IDLE) && bus.cmd_valid_i && cmd_ready_q;
    assign len_legal = (bus.cmd_len_i != '0) && (bus.cmd_len_i <= LenWidth'(MAX_LEN));
    assign last_bit  = ({1'b0, idx_q} == (cmd_q.len - LenWidth'(1)));

    rt_jtag_tck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tck_gen (
        .clk  (clk_i),
        .rst  (rst_i),
        .run  (run),
        .tck  (tck),
        .rise (tck_rise),
        .fall (tck_fall)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = len_legal ? LOW : RESP;
            LOW:     if (tck_rise) state_d = HIGH;
            HIGH:    if (tck_fall) state_d = last_bit ? RESP : LOW;
            RESP:    if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pins only move at LOW entry, so the target always sees a full half-period of setup.
    always_comb begin
        cmd_d = cmd_q;
        idx_d = idx_q;
        tdo_d = tdo_q;
        tms_d = tms_q;
        td_d  = td_q;
        if (accept) begin
            cmd_d.len = bus.cmd_len_i;
            cmd_d.tms = bus.cmd_tms_i;
            cmd_d.tdi = bus.cmd_tdi_i;
            idx_d     = '0;
            tdo_d     = '0;
            if (len_legal) begin
                tms_d = bus.cmd_tms_i[0];
                td_d  = bus.cmd_tdi_i[0];
            end
        end
        if ((state_q == LOW) && tck_rise) begin
            tdo_d[idx_q] = bus.jtag_td_i;
        end
        if ((state_q == HIGH) && tck_fall && !last_bit) begin
            idx_d = idx_q + 5'd1;
            tms_d = cmd_q.tms[idx_d];
            td_d  = cmd_q.tdi[idx_d];
        end
        rsp_valid_d = (state_d == RESP);
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_q       <= '0;
            idx_q       <= '0;
            tdo_q       <= '0;
            tms_q       <= 1'b1;
            td_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            trst_n_q    <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            tdo_q       <= tdo_d;
            tms_q       <= tms_d;
            td_q        <= td_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            trst_n_q    <= 1'b1;
        end
    end

    assign bus.cmd_ready_o  = cmd_ready_q;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_tdo_o    = tdo_q;
    assign bus.jtag_tck_o   = tck;
    assign bus.jtag_tms_o   = tms_q;
    assign bus.jtag_td_o    = td_q;
    assign bus.jtag_trst_no = trst_n_q;

endmodule

// File: tb/tb_rt_jtag_master.sv
// tb/tb_rt_jtag_master.sv - self-checking bench for rt_jtag_master
module tb_rt_jtag_master;

    localparam int CD = 2;

    typedef struct {
        int          len;
        logic [31:0] tms;
        logic [31:0] tdi;
        bit          loop;
        logic [63:0] pat;
        int          hold;
        logic [31:0] exp_tdo;
        int          exp_lat;
        int          exp_pulses;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          loop = 1'b1;
    logic [63:0] pat = '0;
    bit          mon_rst = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    int          n_rise;
    int          hi_run, lo_run, bad_w, pin_chg;
    bit          seen_fall;
    logic        tck_prev, tms_prev, td_prev;
    logic [63:0] obs_tms, obs_tdi;

    rt_jtag_master_if #(.MAX_LEN(32)) bus ();

    rt_jtag_master #(
        .CLK_DIV(CD),
        .MAX_LEN(32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Target: either loop TDI back, or return pattern bit k on the k-th TCK pulse.
    assign bus.jtag_td_i = loop ? bus.jtag_td_o : pat[n_rise[5:0]];

    always @(negedge clk) begin
        if (mon_rst) begin
            n_rise = 0; hi_run = 0; lo_run = 0; bad_w = 0; pin_chg = 0; seen_fall = 0;
            obs_tms = '0; obs_tdi = '0;
        end else if (bus.jtag_tck_o && !tck_prev) begin
            if (n_rise < 64) begin
                obs_tms[n_rise] = bus.jtag_tms_o;
                obs_tdi[n_rise] = bus.jtag_td_o;
            end
            if (seen_fall && lo_run != CD) bad_w++;
            if (bus.jtag_tms_o != tms_prev || bus.jtag_td_o != td_prev) pin_chg++;
            n_rise++;
            hi_run = 1;
        end else if (bus.jtag_tck_o) begin
            hi_run++;
            if (bus.jtag_tms_o != tms_prev || bus.jtag_td_o != td_prev) pin_chg++;
        end else if (tck_prev) begin
            if (hi_run != CD) bad_w++;
            seen_fall = 1;
            lo_run = 1;
        end else begin
            lo_run++;
        end
        tck_prev = bus.jtag_tck_o;
        tms_prev = bus.jtag_tms_o;
        td_prev  = bus.jtag_td_o;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] model_tdo(input int len, input logic [31:0] tdi,
                                              input logic [63:0] p, input bit lb);
        logic [31:0] r;
        r = '0;
        if (len < 1 || len > 32) return r;
        for (int i = 0; i < len; i++) r[i] = lb ? tdi[i] : p[i];
        return r;
    endfunction

    function automatic logic [31:0] len_mask(input int len);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < len && i < 32; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic run_cmd(input vec_t v, input string tag);
        int          k;
        int          bad_hold;
        logic [31:0] held;
        logic [31:0] m;
        k = 0;
        while (!bus.cmd_ready_o && k < 20) begin @(posedge clk); #1; k++; end
        check({tag, " ready"}, bus.cmd_ready_o, 1);
        loop = v.loop;
        pat  = v.pat;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_len_i   = 6'(v.len);
        bus.cmd_tms_i   = v.tms;
        bus.cmd_tdi_i   = v.tdi;
        bus.rsp_ready_i = (v.hold == 0);
        mon_rst = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        mon_rst = 1'b0;
        if (v.exp_pulses > 0)
            check({tag, " bit0 pins"}, {bus.jtag_tck_o, bus.jtag_tms_o, bus.jtag_td_o},
                  {1'b0, v.tms[0], v.tdi[0]});
        k = 1;
        while (!bus.rsp_valid_o && k < 400) begin @(posedge clk); #1; k++; end
        check({tag, " latency"}, k, v.exp_lat);
        held = bus.rsp_tdo_o;
        bad_hold = 0;
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_tdo_o !== held || !bus.rsp_valid_o || bus.cmd_ready_o) bad_hold++;
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        check({tag, " tdo"}, held, v.exp_tdo);
        check({tag, " pulses"}, n_rise, v.exp_pulses);
        check({tag, " after handshake valid/ready"}, {bus.rsp_valid_o, bus.cmd_ready_o}, 2'b01);
        if (v.hold > 0) check({tag, " hold stable"}, bad_hold, 0);
        if (v.exp_pulses > 0) begin
            m = len_mask(v.len);
            check({tag, " tms seq"}, obs_tms[31:0] & m, v.tms & m);
            check({tag, " tdi seq"}, obs_tdi[31:0] & m, v.tdi & m);
            check({tag, " tck widths"}, bad_w, 0);
            check({tag, " pin change while tck high"}, pin_chg, 0);
        end
    endtask

    vec_t tbl[9];
    vec_t v;
    int   k;
    int   sel;

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_len_i   = '0;
        bus.cmd_tms_i   = '0;
        bus.cmd_tdi_i   = '0;
        bus.rsp_ready_i = 1'b0;

        // len, tms, tdi, loop, pat, hold, exp_tdo, exp_lat, exp_pulses
        tbl[0] = '{5,  32'h0000_001F, 32'h0000_0000, 1, 64'h0, 0, 32'h0000_0000, 21,  5};
        tbl[1] = '{8,  32'h0000_0080, 32'h0000_00A5, 1, 64'h0, 0, 32'h0000_00A5, 33,  8};
        tbl[2] = '{32, 32'h0000_0000, 32'hDEAD_BEEF, 1, 64'h0, 10, 32'hDEAD_BEEF, 129, 32};
        tbl[3] = '{0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'h0, 0, 32'h0000_0000, 1,   0};
        tbl[4] = '{40, 32'h0000_FFFF, 32'hFFFF_FFFF, 1, 64'h0, 0, 32'h0000_0000, 1,   0};
        tbl[5] = '{1,  32'h0000_0001, 32'h0000_0001, 1, 64'h0, 0, 32'h0000_0001, 5,   1};
        tbl[6] = '{32, 32'h8000_0001, 32'h0000_0000, 0, 64'h0000_0000_1234_5678, 0,
                   32'h1234_5678, 129, 32};
        tbl[7] = '{12, 32'h0000_0A5A, 32'h0000_0000, 0, 64'hFFFF_FFFF_FFFF_F0F3, 2,
                   32'h0000_00F3, 49, 12};
        tbl[8] = '{33, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1,
                   32'h0000_0000, 1, 0};

        @(posedge clk); #1;
        check("reset tck", bus.jtag_tck_o, 0);
        check("reset tms", bus.jtag_tms_o, 1);
        check("reset tdi", bus.jtag_td_o, 0);
        check("reset trst_n", bus.jtag_trst_no, 0);
        check("reset cmd_ready", bus.cmd_ready_o, 0);
        check("reset rsp_valid/tdo", {bus.rsp_valid_o, bus.rsp_tdo_o}, 33'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("release trst_n", bus.jtag_trst_no, 1);
        check("release cmd_ready", bus.cmd_ready_o, 1);

        for (int i = 0; i < 9; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 25; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       v.len = 0;
                1:       v.len = $urandom_range(33, 63);
                2:       v.len = 1;
                3:       v.len = 32;
                default: v.len = $urandom_range(1, 32);
            endcase
            v.tms  = $urandom;
            v.tdi  = $urandom;
            v.loop = 1'($urandom_range(0, 1));
            v.pat  = {$urandom, $urandom};
            v.hold = $urandom_range(0, 3);
            v.exp_tdo    = model_tdo(v.len, v.tdi, v.pat, v.loop);
            v.exp_pulses = (v.len >= 1 && v.len <= 32) ? v.len : 0;
            v.exp_lat    = (v.exp_pulses > 0) ? 1 + 2 * CD * v.len : 1;
            run_cmd(v, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of the third TCK pulse of a 16-bit command.
        loop = 1'b1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_len_i   = 6'd16;
        bus.cmd_tms_i   = 32'h0;
        bus.cmd_tdi_i   = 32'h0000_F00F;
        mon_rst = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        mon_rst = 1'b0;
        k = 0;
        while (!(n_rise == 3 && bus.jtag_tck_o) && k < 100) begin @(posedge clk); #1; k++; end
        check("midrst reached pulse 3", (n_rise == 3) && bus.jtag_tck_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst tck", bus.jtag_tck_o, 0);
        check("midrst trst_n", bus.jtag_trst_no, 0);
        check("midrst rsp_valid", bus.rsp_valid_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        v = '{4, 32'h0000_0003, 32'h0000_0009, 1, 64'h0, 0, 32'h0000_0009, 17, 4};
        run_cmd(v, "after midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
